alu_response_checker: RTL and testbench
=======================================

// Module: alu_response_checker
// PURPOSE
//  Synthesizable response checker for n_bit_alu, used in self-checking benches and in on-chip BIST.
//  Accepts one ALU transaction per handshake: operands, controls and the DUT's outputs.
//  Recomputes the expected result and flags with an internal golden model, then compares them.
//  Reports pass/fail per transaction, keeps pass/fail counters and latches the first mismatch.
// PARAMETERS
//  N         32  operand/result width (matches n_bit_alu n)
//  CNT_W     16  width of pass/fail counters
//  STOP_ERR  0   1: after the first mismatch, in_ready stays low until clr
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  clr           in   1      synchronous clear of counters, sticky error and first-mismatch capture
//  in_valid      in   1      transaction presented
//  in_ready      out  1      checker can accept
//  a, b          in   N      ALU operands
//  cin           in   1      carry in
//  ainv, binv    in   1      invert a / invert b before the operation
//  select        in   2      00 AND, 01 OR, 10 ADD, 11 SLT
//  dut_result    in   N      DUT result
//  dut_cout      in   1      DUT carry out
//  dut_overflow  in   1      DUT signed overflow
//  dut_zero      in   1      DUT zero flag
//  chk_valid     out  1      one-cycle pulse: comparison done
//  chk_pass      out  1      valid with chk_valid: 1 = match
//  err_sticky    out  1      set on any mismatch; held until clr/rst
//  pass_cnt      out  CNT_W  passing transactions, saturating
//  fail_cnt      out  CNT_W  failing transactions, saturating
//  err_result    out  N      DUT result of the first mismatch
//  err_expect    out  N      expected result of the first mismatch
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and capture registers 0, except in_ready=1 once in IDLE.
//  FSM IDLE -> EVAL -> CMP -> IDLE:
//   IDLE: in_ready=1 (0 if STOP_ERR && err_sticky). Accept when in_valid&in_ready; register every input; go to EVAL.
//   EVAL: in_ready=0. Compute and register the expected values:
//    - Operands: A'=ainv?~a:a, B'=binv?~b:b.
//    - ADD: {c,sum} = A'+B'+cin, computed N+1 bits wide.
//    - Overflow: (A'[N-1]==B'[N-1]) && (sum[N-1]!=A'[N-1]).
//    - SLT: result = {N-1 zeros, sum[N-1]^ovf}; cout and ovf are taken from the same addition.
//    - AND/OR: result = A'&B' / A'|B'; exp cout=0, exp ovf=0.
//    - Expected zero = (exp result == 0).
//   CMP: in_ready=0. Result and zero are always compared. Cout and overflow are compared only for select 10/11.
//    - Pulse chk_valid for 1 cycle with chk_pass; go to IDLE.
//  Latency: accept at edge k -> chk_valid high in the cycle after edge k+2.
//   Throughput: 1 transaction per 3 cycles.
//  Counters: on chk_valid, increment pass_cnt or fail_cnt; each saturates at 2^CNT_W-1 (no wrap).
//  First mismatch: err_result/err_expect load only when err_sticky is 0 at a failing CMP.
//   Later failures leave them unchanged; err_sticky sets in the same edge.
//  clr: zeroes counters, err_sticky, err_result, err_expect. It does not abort an in-flight transaction.
//   clr coincident with a CMP-cycle update: clr wins and that result is not counted.
//   chk_valid/chk_pass still pulse.
//  in_valid while in_ready=0: ignored, not queued. The source must hold in_valid and all inputs until accepted.
//  rst asserted mid-transaction: immediate return to IDLE; the transaction is lost; no chk_valid pulse.
//  Inputs are sampled only at acceptance; later changes do not affect the in-flight check.
// TESTING
//  1. a=5,b=6,cin=1,ainv=0,binv=1,sel=10, dut=FFFFFFFF/c0/v0/z0 -> chk_pass=1, pass_cnt=1, 3-cycle latency.
//  2. a=5,b=6,sel=00, dut_result=4,z=0 -> pass; then dut_result=5 -> chk_pass=0.
//     After the failure: fail_cnt=1, err_sticky=1, err_result=5, err_expect=4.
//  3. a=7FFFFFFF,b=1,cin=0,sel=10, dut ovf=1,res=80000000 -> pass; same with dut ovf=0 -> fail.
//  4. a=3,b=5,binv=1,cin=1,sel=11 (SLT), dut_result=1 -> pass.
//     A second mismatch after test 2: err_result/err_expect unchanged, fail_cnt=2.
//  5. STOP_ERR=1: after a fail, in_valid held 10 cycles -> in_ready=0, no accept.
//     Pulse clr -> counters/sticky=0, in_ready=1.
//  6. rst pulsed in EVAL -> no chk_valid, all outputs 0, in_ready=1 next cycle.
//     CNT_W=2: 5 passes -> pass_cnt stays 3.

Source files
------------

// File: rtl/alu_response_checker.sv
// Response checker for n_bit_alu: captures one transaction per handshake, recomputes
// the expected result/flags, compares, counts pass/fail and latches the first mismatch.
module alu_response_checker #(
    parameter int N        = 32,
    parameter int CNT_W    = 16,
    parameter bit STOP_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    input  logic             ainv,
    input  logic             binv,
    input  logic [1:0]       select,
    input  logic [N-1:0]     dut_result,
    input  logic             dut_cout,
    input  logic             dut_overflow,
    input  logic             dut_zero,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic             err_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [N-1:0]     err_result,
    output logic [N-1:0]     err_expect
);

    typedef enum logic [1:0] {IDLE, EVAL, CMP} state_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         ainv;
        logic         binv;
        logic [1:0]   select;
        logic [N-1:0] result;
        logic         cout;
        logic         ovf;
        logic         zero;
    } txn_t;

    state_t       state, state_nxt;
    txn_t         txn;
    logic         accept;
    logic [N-1:0] ap, bp, sum, exp_res_c;
    logic         carry, ovf_c;
    logic [N-1:0] exp_result;
    logic         exp_cout, exp_ovf, exp_zero;
    logic         match;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !(STOP_ERR && err_sticky);
                if (in_valid && !(STOP_ERR && err_sticky)) begin
                    accept    = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL:    state_nxt = CMP;
            CMP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Golden model; SLT reuses the subtraction carry/overflow as the ALU does.
    always_comb begin
        ap = txn.ainv ? ~txn.a : txn.a;
        bp = txn.binv ? ~txn.b : txn.b;
        {carry, sum} = {1'b0, ap} + {1'b0, bp} + {{N{1'b0}}, txn.cin};
        ovf_c = (ap[N-1] == bp[N-1]) && (sum[N-1] != ap[N-1]);
        case (txn.select)
            2'b00:   exp_res_c = ap & bp;
            2'b01:   exp_res_c = ap | bp;
            2'b10:   exp_res_c = sum;
            default: exp_res_c = {{(N-1){1'b0}}, sum[N-1] ^ ovf_c};
        endcase
    end

    // Carry/overflow only matter for the arithmetic selects.
    assign match = (txn.result == exp_result) && (txn.zero == exp_zero) &&
                   (!txn.select[1] || ((txn.cout == exp_cout) && (txn.ovf == exp_ovf)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            txn        <= '0;
            exp_result <= '0;
            exp_cout   <= 1'b0;
            exp_ovf    <= 1'b0;
            exp_zero   <= 1'b0;
            chk_valid  <= 1'b0;
            chk_pass   <= 1'b0;
            err_sticky <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_result <= '0;
            err_expect <= '0;
        end else begin
            state     <= state_nxt;
            chk_valid <= (state == CMP);
            chk_pass  <= (state == CMP) && match;
            if (accept)
                txn <= '{a: a, b: b, cin: cin, ainv: ainv, binv: binv, select: select,
                         result: dut_result, cout: dut_cout, ovf: dut_overflow, zero: dut_zero};
            if (state == EVAL) begin
                exp_result <= exp_res_c;
                exp_cout   <= txn.select[1] ? carry : 1'b0;
                exp_ovf    <= txn.select[1] ? ovf_c : 1'b0;
                exp_zero   <= (exp_res_c == '0);
            end
            // clr beats a coincident compare: that result is dropped.
            if (clr) begin
                err_sticky <= 1'b0;
                pass_cnt   <= '0;
                fail_cnt   <= '0;
                err_result <= '0;
                err_expect <= '0;
            end else if (state == CMP) begin
                if (match) begin
                    if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
                    if (!err_sticky) begin
                        err_result <= txn.result;
                        err_expect <= exp_result;
                    end
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed bench for alu_response_checker: default, STOP_ERR=1 and CNT_W=2 instances.
module tb_alu_response_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0, dres = '0;
    logic        cin = 1'b0, ainv = 1'b0, binv = 1'b0, dc = 1'b0, dv = 1'b0, dz = 1'b0;
    logic [1:0]  sel = '0;
    logic [2:0]  iv = '0, clr = '0;
    logic [2:0]  rdy, cv, cp, es;
    logic [15:0] pc0, fc0, pc1, fc1;
    logic [1:0]  pc2, fc2;
    logic [31:0] er [3];
    logic [31:0] ee [3];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    alu_response_checker d0 (
        .clk(clk), .rst(rst), .clr(clr[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
        .a(a), .b(b), .cin(cin), .ainv(ainv), .binv(binv), .select(sel),
        .dut_result(dres), .dut_cout(dc), .dut_overflow(dv), .dut_zero(dz),
        .chk_valid(cv[0]), .chk_pass(cp[0]), .err_sticky(es[0]),
        .pass_cnt(pc0), .fail_cnt(fc0), .err_result(er[0]), .err_expect(ee[0]));

    alu_response_checker #(.STOP_ERR(1'b1)) d1 (
        .clk(clk), .rst(rst), .clr(clr[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
        .a(a), .b(b), .cin(cin), .ainv(ainv), .binv(binv), .select(sel),
        .dut_result(dres), .dut_cout(dc), .dut_overflow(dv), .dut_zero(dz),
        .chk_valid(cv[1]), .chk_pass(cp[1]), .err_sticky(es[1]),
        .pass_cnt(pc1), .fail_cnt(fc1), .err_result(er[1]), .err_expect(ee[1]));

    alu_response_checker #(.CNT_W(2)) d2 (
        .clk(clk), .rst(rst), .clr(clr[2]), .in_valid(iv[2]), .in_ready(rdy[2]),
        .a(a), .b(b), .cin(cin), .ainv(ainv), .binv(binv), .select(sel),
        .dut_result(dres), .dut_cout(dc), .dut_overflow(dv), .dut_zero(dz),
        .chk_valid(cv[2]), .chk_pass(cp[2]), .err_sticky(es[2]),
        .pass_cnt(pc2), .fail_cnt(fc2), .err_result(er[2]), .err_expect(ee[2]));

    // Present one transaction to instance d, scramble inputs after acceptance,
    // then wait (bounded) for chk_valid; lat counts negedges after the accept edge.
    task automatic send(input int d, input logic [31:0] ta, tb, input logic tcin, tai, tbi,
                        input logic [1:0] ts, input logic [31:0] tr, input logic tc, tv, tz,
                        output logic got, output logic pass, output int lat);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; ainv = tai; binv = tbi; sel = ts;
        dres = tr; dc = tc; dv = tv; dz = tz; iv[d] = 1'b1;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; dres = ~tr; dc = ~tc; dv = ~tv; dz = ~tz;
        sel = ~ts; ainv = ~tai; binv = ~tbi; cin = ~tcin;
        got = 1'b0; pass = 1'b0; lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (cv[d]) begin
                got = 1'b1;
                pass = cp[d];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vecs++; if (rdy !== 3'b111) begin errs++; $display("FAIL reset_ready got=%b want=111", rdy); end
        vecs++; if (cv !== 3'b000 || cp !== 3'b000 || es !== 3'b000) begin errs++;
            $display("FAIL reset_flags cv=%b cp=%b es=%b want 0", cv, cp, es); end
        vecs++; if (pc0 !== 16'd0 || fc0 !== 16'd0 || er[0] !== 32'd0 || ee[0] !== 32'd0) begin errs++;
            $display("FAIL reset_regs pc=%0d fc=%0d er=%h ee=%h want 0", pc0, fc0, er[0], ee[0]); end
    endtask

    task automatic test_add();
        logic g, p; int l;
        send(0, 32'd5, 32'd6, 1'b1, 1'b0, 1'b1, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, g, p, l);
        vecs++; if (!g || !p) begin errs++; $display("FAIL add_pass got=%b pass=%b want 1/1", g, p); end
        vecs++; if (l !== 3) begin errs++; $display("FAIL add_latency got=%0d want=3", l); end
        vecs++; if (pc0 !== 16'd1 || fc0 !== 16'd0) begin errs++;
            $display("FAIL add_counts pc=%0d fc=%0d want 1/0", pc0, fc0); end
        vecs++; if (rdy[0] !== 1'b1) begin errs++; $display("FAIL add_ready_b2b got=%b want=1", rdy[0]); end
        @(negedge clk);
        vecs++; if (cv[0] !== 1'b0) begin errs++; $display("FAIL add_pulse_width cv=%b want=0", cv[0]); end
    endtask

    task automatic test_and();
        logic g, p; int l;
        send(0, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 2'b00, 32'd4, 1'b1, 1'b1, 1'b0, g, p, l);
        vecs++; if (!g || !p) begin errs++; $display("FAIL and_pass got=%b pass=%b want 1/1", g, p); end
        send(0, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 2'b00, 32'd5, 1'b0, 1'b0, 1'b0, g, p, l);
        vecs++; if (!g || p) begin errs++; $display("FAIL and_fail got=%b pass=%b want 1/0", g, p); end
        vecs++; if (pc0 !== 16'd2 || fc0 !== 16'd1 || es[0] !== 1'b1) begin errs++;
            $display("FAIL and_counts pc=%0d fc=%0d es=%b want 2/1/1", pc0, fc0, es[0]); end
        vecs++; if (er[0] !== 32'd5 || ee[0] !== 32'd4) begin errs++;
            $display("FAIL and_capture er=%h ee=%h want 5/4", er[0], ee[0]); end
    endtask

    task automatic test_overflow();
        logic g, p; int l;
        send(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h8000_0000, 1'b0, 1'b1, 1'b0, g, p, l);
        vecs++; if (!g || !p) begin errs++; $display("FAIL ovf_pass got=%b pass=%b want 1/1", g, p); end
        send(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h8000_0000, 1'b0, 1'b0, 1'b0, g, p, l);
        vecs++; if (!g || p) begin errs++; $display("FAIL ovf_fail got=%b pass=%b want 1/0", g, p); end
        vecs++; if (fc0 !== 16'd2 || er[0] !== 32'd5 || ee[0] !== 32'd4) begin errs++;
            $display("FAIL ovf_first_kept fc=%0d er=%h ee=%h want 2/5/4", fc0, er[0], ee[0]); end
    endtask

    task automatic test_slt();
        logic g, p; int l;
        send(0, 32'd3, 32'd5, 1'b1, 1'b0, 1'b1, 2'b11, 32'd1, 1'b0, 1'b0, 1'b0, g, p, l);
        vecs++; if (!g || !p) begin errs++; $display("FAIL slt_pass got=%b pass=%b want 1/1", g, p); end
        send(0, 32'd3, 32'd5, 1'b1, 1'b0, 1'b1, 2'b11, 32'd0, 1'b0, 1'b0, 1'b1, g, p, l);
        vecs++; if (!g || p) begin errs++; $display("FAIL slt_fail got=%b pass=%b want 1/0", g, p); end
        vecs++; if (pc0 !== 16'd4 || fc0 !== 16'd3 || er[0] !== 32'd5) begin errs++;
            $display("FAIL slt_counts pc=%0d fc=%0d er=%h want 4/3/5", pc0, fc0, er[0]); end
    endtask

    task automatic test_clr_in_cmp();
        @(negedge clk);
        a = 32'd5; b = 32'd6; cin = 1'b0; ainv = 1'b0; binv = 1'b0; sel = 2'b00;
        dres = 32'd7; dc = 1'b0; dv = 1'b0; dz = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(negedge clk);            // EVAL
        @(negedge clk);            // CMP
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        vecs++; if (cv[0] !== 1'b1 || cp[0] !== 1'b0) begin errs++;
            $display("FAIL clr_cmp_pulse cv=%b cp=%b want 1/0", cv[0], cp[0]); end
        vecs++; if (pc0 !== 16'd0 || fc0 !== 16'd0 || es[0] !== 1'b0 || er[0] !== 32'd0 || ee[0] !== 32'd0) begin
            errs++; $display("FAIL clr_cmp_regs pc=%0d fc=%0d es=%b er=%h ee=%h want 0",
                             pc0, fc0, es[0], er[0], ee[0]); end
    endtask

    task automatic test_stop_err();
        logic g, p, seen, rdy_hi; int l;
        send(1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 2'b00, 32'd5, 1'b0, 1'b0, 1'b0, g, p, l);
        vecs++; if (!g || p || es[1] !== 1'b1 || rdy[1] !== 1'b0) begin errs++;
            $display("FAIL stop_after_fail got=%b pass=%b es=%b rdy=%b want 1/0/1/0", g, p, es[1], rdy[1]); end
        a = 32'd5; b = 32'd6; sel = 2'b00; dres = 32'd4; iv[1] = 1'b1;
        seen = 1'b0; rdy_hi = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cv[1]) seen = 1'b1;
            if (rdy[1]) rdy_hi = 1'b1;
        end
        iv[1] = 1'b0;
        vecs++; if (seen || rdy_hi || fc1 !== 16'd1) begin errs++;
            $display("FAIL stop_hold seen=%b rdy_hi=%b fc=%0d want 0/0/1", seen, rdy_hi, fc1); end
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        vecs++; if (rdy[1] !== 1'b1 || es[1] !== 1'b0 || fc1 !== 16'd0 || pc1 !== 16'd0) begin errs++;
            $display("FAIL stop_clr rdy=%b es=%b fc=%0d pc=%0d want 1/0/0/0", rdy[1], es[1], fc1, pc1); end
    endtask

    task automatic test_reset_mid();
        logic g, p, seen; int l;
        send(0, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 2'b01, 32'd7, 1'b0, 1'b0, 1'b0, g, p, l);
        vecs++; if (!g || !p || pc0 !== 16'd1) begin errs++;
            $display("FAIL rmid_pre got=%b pass=%b pc=%0d want 1/1/1", g, p, pc0); end
        @(negedge clk);
        a = 32'd1; b = 32'd1; sel = 2'b10; dres = 32'd2; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(negedge clk);            // EVAL
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (cv[0]) seen = 1'b1;
        end
        vecs++; if (seen) begin errs++; $display("FAIL rmid_no_pulse seen=%b want=0", seen); end
        vecs++; if (rdy[0] !== 1'b1 || pc0 !== 16'd0 || fc0 !== 16'd0 || cp[0] !== 1'b0) begin errs++;
            $display("FAIL rmid_state rdy=%b pc=%0d fc=%0d cp=%b want 1/0/0/0", rdy[0], pc0, fc0, cp[0]); end
    endtask

    task automatic test_saturate();
        logic g, p; int l;
        logic [1:0] want;
        for (int i = 1; i <= 5; i++) begin
            send(2, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0, 2'b00, 32'd1, 1'b0, 1'b0, 1'b0, g, p, l);
            want = (i > 3) ? 2'd3 : 2'(i);
            vecs++; if (!g || !p || pc2 !== want) begin errs++;
                $display("FAIL sat_pass%0d got=%b pass=%b pc=%0d want 1/1/%0d", i, g, p, pc2, want); end
        end
        vecs++; if (fc2 !== 2'd0) begin errs++; $display("FAIL sat_fail_cnt got=%0d want=0", fc2); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_and();
        test_overflow();
        test_slt();
        test_clr_in_cmp();
        test_stop_err();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
